// File: rtl/dma_pkg.sv
// Shared types, constants and helpers for the DMA channel arbiter.
// Priority order encoding: {p3,p2,p1,p0}, two bits per slot, p0 = highest priority.
package dma_pkg;

  localparam int NCH = 4;

  localparam logic [2*NCH-1:0] DEFAULT_PRIORITY_ORDER = 8'b11_10_01_00;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_REQ = 2'd1,
    GRANTED  = 2'd2,
    RELEASE  = 2'd3
  } arbState_t;

  // Channel index to one-hot acknowledge vector.
  function automatic logic [NCH-1:0] onehot2(input logic [1:0] ch);
    onehot2 = 4'b0001 << ch;
  endfunction

  // Move the served channel to the lowest-priority slot (p3); the remaining
  // channels close the gap while keeping their relative order.
  function automatic logic [2*NCH-1:0] rotateOrder(input logic [2*NCH-1:0] order,
                                                    input logic [1:0]       served);
    logic [2*NCH-1:0] res;
    int               j;
    res = '0;
    j   = 0;
    for (int i = 0; i < NCH; i++) begin
      if (order[2*i +: 2] != served) begin
        res[2*j +: 2] = order[2*i +: 2];
        j++;
      end
    end
    res[2*NCH-1 -: 2] = served;
    return res;
  endfunction

endpackage

// File: rtl/dma_priority_encoder.sv
// Combinational winner selection: scans the priority order p0..p3 and returns
// the first channel whose effective request is set.
module dma_priority_encoder
  import dma_pkg::*;
(
  input  logic [NCH-1:0]   effReq,
  input  logic [2*NCH-1:0] priorityOrder,
  output logic [1:0]       winner,
  output logic             anyReq
);

  // Scan from p3 down to p0 so the highest-priority requester is written last.
  always_comb begin
    winner = '0;
    anyReq = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (effReq[priorityOrder[2*i +: 2]]) begin
        winner = priorityOrder[2*i +: 2];
        anyReq = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_channel_arbiter.sv
// DMA channel arbiter: resolves DREQ into one granted channel, runs the
// HRQ/HLDA hold handshake and drives one-hot DACK. Fixed or rotating priority.
// Optional feature macro: DMA_SW_REQ_EN adds the swReq port, ORed into the
// effective request vector.
//
// Handshake: HRQ is raised while a request is pending (HOLD_REQ) and kept
// through GRANTED. A grant happens only on a cycle where HLDA=1 and a request
// is still present; DACK follows on the next edge. HLDA falling in GRANTED
// aborts the transfer. HRQ and DACK are both low in RELEASE and IDLE.
module dma_channel_arbiter
  import dma_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int REL_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [NCH-1:0]   DREQ,
  input  logic [NCH-1:0]   maskReg,
  input  logic             priorityType,
  input  logic [NCH-1:0]   singleMode,
  input  logic             HLDA,
  input  logic             xferDone,
  input  logic             EOP_N,
`ifdef DMA_SW_REQ_EN
  input  logic [NCH-1:0]   swReq,
`endif
  output logic             HRQ,
  output logic [NCH-1:0]   DACK,
  output logic [1:0]       activeCh,
  output logic             grantValid,
  output logic [2*NCH-1:0] priorityOrder,
  output arbState_t        stateDbg
);

  arbState_t        state;
  arbState_t        stateNext;
  logic [NCH-1:0]   effReq;
  logic [1:0]       winner;
  logic             anyReq;
  logic             latchWinner;
  logic             normalDone;
  logic             enterRelease;
  logic [7:0]       relCnt;
  logic             prevPriorityType;
  logic             ptFall;
  logic             reloadPending;
  logic             reloadPendingNext;
  logic [2*NCH-1:0] orderNext;
  logic [1:0]       activeChNext;
  logic             hrqNext;
  logic             grantNext;
  logic [NCH-1:0]   dackNext;

`ifdef DMA_SW_REQ_EN
  assign effReq = (DREQ | swReq) & ~maskReg;
`else
  assign effReq = DREQ & ~maskReg;
`endif

  assign ptFall   = prevPriorityType & ~priorityType;
  assign stateDbg = state;

  dma_priority_encoder u_encoder (
    .effReq        (effReq),
    .priorityOrder (priorityOrder),
    .winner        (winner),
    .anyReq        (anyReq)
  );

  // Next-state logic; EOP_N has precedence over HLDA abort and xferDone.
  always_comb begin
    stateNext   = state;
    latchWinner = 1'b0;
    normalDone  = 1'b0;
    case (state)
      IDLE: begin
        if (anyReq) stateNext = HOLD_REQ;
      end
      HOLD_REQ: begin
        if (!anyReq) begin
          stateNext = IDLE;
        end else if (HLDA) begin
          stateNext   = GRANTED;
          latchWinner = 1'b1;
        end
      end
      GRANTED: begin
        if (!EOP_N) begin
          stateNext  = RELEASE;
          normalDone = 1'b1;
        end else if (!HLDA) begin
          stateNext = RELEASE;
        end else if (xferDone && (singleMode[activeCh] || !DREQ[activeCh])) begin
          stateNext  = RELEASE;
          normalDone = 1'b1;
        end
      end
      RELEASE: begin
        if (relCnt == 8'd0) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    enterRelease = (state == GRANTED) && (stateNext == RELEASE);
  end

  // Priority-order update: reload on priorityType 1->0 (deferred while a
  // channel owns the bus), rotation only on a normal completion.
  always_comb begin
    orderNext         = priorityOrder;
    reloadPendingNext = reloadPending;
    if (state == GRANTED) begin
      if (ptFall) reloadPendingNext = 1'b1;
      if (enterRelease) begin
        if (reloadPending || ptFall) begin
          orderNext         = DEFAULT_PRIORITY_ORDER;
          reloadPendingNext = 1'b0;
        end else if (normalDone && priorityType) begin
          orderNext = rotateOrder(priorityOrder, activeCh);
        end
      end
    end else if (ptFall) begin
      orderNext = DEFAULT_PRIORITY_ORDER;
    end
  end

  // Output values derived from the next state so the outputs leave flops.
  always_comb begin
    activeChNext = latchWinner ? winner : activeCh;
    hrqNext      = (stateNext == HOLD_REQ) || (stateNext == GRANTED);
    grantNext    = (stateNext == GRANTED);
    dackNext     = grantNext ? onehot2(activeChNext) : '0;
  end

  // State register and release-hold counter.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      relCnt <= '0;
    end else begin
      state <= stateNext;
      if (enterRelease) begin
        relCnt <= 8'(REL_CYCLES - 1);
      end else if (state == RELEASE && relCnt != 8'd0) begin
        relCnt <= relCnt - 8'd1;
      end
    end
  end

  // Priority-order register and priorityType edge tracking.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      priorityOrder    <= DEFAULT_PRIORITY_ORDER;
      prevPriorityType <= 1'b0;
      reloadPending    <= 1'b0;
    end else begin
      priorityOrder    <= orderNext;
      prevPriorityType <= priorityType;
      reloadPending    <= reloadPendingNext;
    end
  end

  // Registered bus-side outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      HRQ        <= 1'b0;
      DACK       <= '0;
      activeCh   <= '0;
      grantValid <= 1'b0;
    end else begin
      HRQ        <= hrqNext;
      DACK       <= dackNext;
      activeCh   <= activeChNext;
      grantValid <= grantNext;
    end
  end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed testbench for dma_channel_arbiter (default build, REL_CYCLES=1).
module tb_dma_channel_arbiter;
  import dma_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] dreq;
  logic [3:0] mask_reg;
  logic       priority_type;
  logic [3:0] single_mode;
  logic       hlda;
  logic       xfer_done;
  logic       eop_n;
`ifdef DMA_SW_REQ_EN
  logic [3:0] sw_req;
`endif
  logic       hrq;
  logic [3:0] dack;
  logic [1:0] active_ch;
  logic       grant_valid;
  logic [7:0] priority_order;
  arbState_t  state_dbg;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  dma_channel_arbiter #(.NCH(4), .REL_CYCLES(1)) dut (
    .CLK           (clk),
    .RESET_N       (rst_n),
    .DREQ          (dreq),
    .maskReg       (mask_reg),
    .priorityType  (priority_type),
    .singleMode    (single_mode),
    .HLDA          (hlda),
    .xferDone      (xfer_done),
    .EOP_N         (eop_n),
`ifdef DMA_SW_REQ_EN
    .swReq         (sw_req),
`endif
    .HRQ           (hrq),
    .DACK          (dack),
    .activeCh      (active_ch),
    .grantValid    (grant_valid),
    .priorityOrder (priority_order),
    .stateDbg      (state_dbg)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] lowest_bit(input logic [3:0] v);
    for (int b = 0; b < 4; b++) if (v[b]) return 4'(1 << b);
    return 4'b0000;
  endfunction

  // One single-mode transfer; leaves the DUT in IDLE.
  task automatic serve(input logic [3:0] req, input logic [3:0] exp_dack, input string tag);
    dreq = req;
    tick();
    check({tag, "_hrq"}, 8'(hrq), 8'(req != 4'd0));
    tick();
    check({tag, "_dack"}, 8'(dack), 8'(exp_dack));
    dreq = 4'd0;
    xfer_done = (req != 4'd0);
    tick();
    xfer_done = 1'b0;
    check({tag, "_rel"}, 8'({hrq, dack}), 8'd0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; dreq = '0; mask_reg = '0; priority_type = 1'b0;
    single_mode = 4'hF; hlda = 1'b0; xfer_done = 1'b0; eop_n = 1'b1;
`ifdef DMA_SW_REQ_EN
    sw_req = '0;
`endif
    tick(); tick();
    check("rst_hrq", 8'(hrq), 8'd0);
    check("rst_dack", 8'(dack), 8'd0);
    check("rst_active", 8'(active_ch), 8'd0);
    check("rst_gv", 8'(grant_valid), 8'd0);
    check("rst_order", priority_order, 8'hE4);
    check("rst_state", 8'(state_dbg), 8'(IDLE));
    rst_n = 1'b1;
    hlda  = 1'b1;
    tick();

    // fixed priority, DREQ=1010: HRQ at +1, DACK at +2
    dreq = 4'b1010;
    tick();
    check("fx_hrq", 8'(hrq), 8'd1);
    check("fx_dack0", 8'(dack), 8'd0);
    tick();
    check("fx_dack", 8'(dack), 8'b0010);
    check("fx_active", 8'(active_ch), 8'd1);
    check("fx_gv", 8'(grant_valid), 8'd1);
    dreq = 4'd0; xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    check("fx_rel_state", 8'(state_dbg), 8'(RELEASE));
    tick();
    check("fx_idle", 8'(state_dbg), 8'(IDLE));

    // sweep all DREQ values under fixed priority
    for (int v = 0; v < 16; v++) exp_q.push_back(lowest_bit(4'(v)));
    for (int v = 0; v < 16; v++) serve(4'(v), exp_q.pop_front(), $sformatf("sweep%0d", v));
    check("sweep_order", priority_order, 8'hE4);

    // rotating priority: ch0 then ch1
    priority_type = 1'b1;
    dreq = 4'b0011;
    tick(); tick();
    check("rot_dack0", 8'(dack), 8'b0001);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    check("rot_order1", priority_order, 8'b00_11_10_01);
    tick(); tick(); tick();
    check("rot_dack1", 8'(dack), 8'b0010);
    dreq = 4'd0; xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    check("rot_order2", priority_order, 8'b01_00_11_10);
    tick();

    // reload deferred while GRANTED, applied on release
    dreq = 4'b0100;
    tick(); tick();
    check("rld_dack", 8'(dack), 8'b0100);
    priority_type = 1'b0;
    tick();
    check("rld_defer", priority_order, 8'b01_00_11_10);
    check("rld_hold_dack", 8'(dack), 8'b0100);
    dreq = 4'd0; xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    check("rld_apply", priority_order, 8'hE4);
    tick();

    // demand mode: stays granted across xferDone while DREQ[2] held
    single_mode = 4'h0;
    dreq = 4'b0100;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      xfer_done = 1'b1;
      tick();
      xfer_done = 1'b0;
      check($sformatf("dem_dack%0d", k), 8'(dack), 8'b0100);
      check($sformatf("dem_state%0d", k), 8'(state_dbg), 8'(GRANTED));
      tick();
    end
    dreq = 4'd0; xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    check("dem_rel", 8'(state_dbg), 8'(RELEASE));
    check("dem_dack_off", 8'(dack), 8'd0);
    tick();

    // EOP_N together with xferDone; request held through RELEASE
    dreq = 4'b1000;
    tick(); tick();
    check("eop_dack", 8'(dack), 8'b1000);
    eop_n = 1'b0; xfer_done = 1'b1;
    tick();
    eop_n = 1'b1; xfer_done = 1'b0;
    check("eop_state", 8'(state_dbg), 8'(RELEASE));
    check("eop_off", 8'({hrq, dack}), 8'd0);
    tick();
    check("eop_idle", 8'(state_dbg), 8'(IDLE));
    check("eop_idle_hrq", 8'(hrq), 8'd0);
    tick();
    check("eop_rereq", 8'(hrq), 8'd1);
    dreq = 4'd0;
    tick();
    check("drop_hrq", 8'(hrq), 8'd0);
    check("drop_state", 8'(state_dbg), 8'(IDLE));

    // masking
    single_mode = 4'hF;
    mask_reg = 4'b0001; dreq = 4'b0001;
    tick(); tick();
    check("mask_hrq", 8'(hrq), 8'd0);
    check("mask_state", 8'(state_dbg), 8'(IDLE));

    // HLDA abort: no rotation even in rotating mode
    mask_reg = 4'd0; priority_type = 1'b1;
    tick(); tick();
    check("abt_dack", 8'(dack), 8'b0001);
    hlda = 1'b0;
    tick();
    check("abt_off", 8'(dack), 8'd0);
    check("abt_order", priority_order, 8'hE4);
    hlda = 1'b1; dreq = 4'd0;
    tick();

    // rotation, then asynchronous reset mid-GRANTED
    serve(4'b0010, 4'b0010, "pre_rst");
    check("pre_rst_order", priority_order, 8'h78);
    dreq = 4'b0001;
    tick(); tick();
    check("pre_rst_dack", 8'(dack), 8'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_hrq", 8'(hrq), 8'd0);
    check("arst_dack", 8'(dack), 8'd0);
    check("arst_order", priority_order, 8'hE4);
    check("arst_gv", 8'(grant_valid), 8'd0);
    check("arst_state", 8'(state_dbg), 8'(IDLE));
    dreq = 4'd0;
    tick();
    rst_n = 1'b1;
    tick();

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
